register_file: RTL
==================

# register_file

Architectural integer register file for the sequential RV64I core; sits directly upstream of the ALU and supplies its two 64-bit operands. It provides two combinational read ports, one clocked write port with optional same-cycle write-to-read bypass, hardwired x0, and a per-register pending scoreboard. The scoreboard lets multi-cycle producers (loads) mark a destination busy and raise a stall until write-back.

## Interface
- `XLEN`, 64, register width
- `NREG`, 32, number of architectural registers; address width is log2(NREG) = 5
- `BYPASS`, 1, 1 = a same-cycle write is visible on the read ports; 0 = read returns the old value
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all registers and pending bits
- `rs1_addr`  in  5  read port 1 address
- `rs2_addr`  in  5  read port 2 address
- `rd_addr`  in  5  write address
- `reg_write`  in  1  write enable
- `write_data`  in  XLEN  write value
- `pend_set`  in  1  mark `pend_addr` pending (issue of a multi-cycle producer)
- `pend_addr`  in  5  register to mark pending
- `read_data1`  out  XLEN  operand for ALU `in1`
- `read_data2`  out  XLEN  operand for ALU `in2`
- `stall`  out  1  a valid source register is pending
- `pending`  out  NREG  pending bit vector, for debug and verification

## Operation
- Storage is NREG×XLEN flops. Entry 0 always reads 0 and is never written. A write to x0 is discarded silently.
- Read: `read_dataN` = 0 if `rsN_addr`==0.
- Otherwise, with BYPASS=1, `reg_write` high, and `rd_addr`==`rsN_addr`: `read_dataN` = `write_data`.
- In all remaining cases, `read_dataN` = the stored value.
- Write: on the rising edge with `reg_write` high and `rd_addr`≠0, regs[`rd_addr`] ← `write_data`.
- Scoreboard, per register i≠0, on each rising edge:
  - Set to 1 if `pend_set` and `pend_addr`==i.
  - Else cleared to 0 if `reg_write` and `rd_addr`==i.
  - Else held.
  - Set wins over clear on the same register in the same cycle: the write retires the older producer, and the set belongs to a newer one.
- `pending[0]` is constant 0. `pend_set` to x0 is ignored.
- `stall` = `pending[rs1_addr]` | `pending[rs2_addr]`.
- `stall` uses registered bits only. It is not cleared early by a same-cycle write to that register, which keeps `stall` free of combinational loops through the write port.
- Both read ports read the same address independently, with no arbitration.
- The ALU consumes `instruction` separately. This block does not decode opcodes; callers drive `rs2_addr` as don't-care for I-type, and the operand mux lives outside.

## Timing
- Read latency 0 cycles (combinational from addresses, and from `write_data`/`reg_write` when BYPASS=1).
- Write latency 1 cycle: the value is visible from storage on the cycle after the edge; with BYPASS=1 it is also visible in the write cycle itself.
- Pending latency 1 cycle: the set appears on `pending`/`stall` the cycle after `pend_set`. A clear likewise takes effect the cycle after the write.
- Reset values: all regs 0, `pending` = 0, `stall` = 0. `read_data1`/`read_data2` = 0 while `reset` is high.
- Reset asserted mid-operation zeroes state immediately (asynchronously). A write presented in the same cycle as `reset` is lost.
- Release is synchronised externally; the first write is accepted on the first rising edge with `reset` low.

## Structure
- Shared package `riscv_pkg`: `XLEN`, `NREG`, `REG_ADDR_W` = 5, and the `reg_addr_t` typedef. The ALU and decoder consume the same constants.
- One sub-module, `reg_scoreboard`: holds the NREG pending flops, the set/clear priority and the `stall` lookup.
- The storage array and read/bypass muxes stay in `register_file`.

## Test plan
- Reset, then read all 32 addresses on both ports → every read returns 0; `pending`=0, `stall`=0.
- Write x5 ← 0xDEADBEEF_CAFEF00D, with rs1=5 in the same cycle:
  - BYPASS=1 → `read_data1`=0xDEADBEEF_CAFEF00D in that cycle.
  - BYPASS=0 → `read_data1`=0 in that cycle.
  - Next cycle, both settings → 0xDEADBEEF_CAFEF00D.
- Write x0 ← 0xFFFF_FFFF_FFFF_FFFF, then rs1=rs2=0 → both ports 0, including in the write cycle with BYPASS=1.
- `pend_set` x7; next cycle rs2=7 → `stall`=1. Write x7 ← 42; next cycle → `stall`=0 and `read_data2`=42.
- `pend_set` x9 and write x9 in the same cycle → next cycle `pending[9]`=1. A further write x9 → `pending[9]`=0.
- Write x3 ← 1 and `pend_set` x3, then assert `reset` mid-cycle → immediately x3 reads 0, `pending`=0, `stall`=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64I core constants: register width, register count and
// register-address type used by the register file, ALU and decoder.
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/register_file_if.sv
// Register file access bundle: two read ports, one write port, pending
// scoreboard control and the resulting operands/stall.
interface register_file_if;
  import riscv_pkg::*;

  reg_addr_t         rs1_addr;
  reg_addr_t         rs2_addr;
  reg_addr_t         rd_addr;
  logic              reg_write;
  xlen_t             write_data;
  logic              pend_set;
  reg_addr_t         pend_addr;
  xlen_t             read_data1;
  xlen_t             read_data2;
  logic              stall;
  logic [NREG-1:0]   pending;

  modport master (
    output rs1_addr, rs2_addr, rd_addr, reg_write, write_data,
           pend_set, pend_addr,
    input  read_data1, read_data2, stall, pending
  );

  modport slave (
    input  rs1_addr, rs2_addr, rd_addr, reg_write, write_data,
           pend_set, pend_addr,
    output read_data1, read_data2, stall, pending
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending flags for multi-cycle producers. A new producer
// (pend_set) wins over a write-back that retires the older one; stall is
// looked up from registered flags only.
module reg_scoreboard
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            pend_set,
  input  reg_addr_t       pend_addr,
  input  logic            reg_write,
  input  reg_addr_t       rd_addr,
  input  reg_addr_t       rs1_addr,
  input  reg_addr_t       rs2_addr,
  output logic [NREG-1:0] pending,
  output logic            stall
);

  logic [NREG-1:1] pend_q;

  // Set on issue, clear on write-back, set takes priority; x0 has no flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (pend_set && pend_addr == reg_addr_t'(i)) begin
          pend_q[i] <= 1'b1;
        end else if (reg_write && rd_addr == reg_addr_t'(i)) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  assign pending = {pend_q, 1'b0};
  assign stall   = pending[rs1_addr] | pending[rs2_addr];

endmodule

// File: rtl/register_file.sv
// Architectural integer register file: NREG x XLEN storage with hardwired
// x0, two combinational read ports with optional write-to-read bypass, one
// clocked write port and a pending scoreboard for multi-cycle producers.
module register_file
  import riscv_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  register_file_if.slave  rf
);

  xlen_t regs [NREG];
  logic  bypass_hit1;
  logic  bypass_hit2;

  // Storage update; x0 is never written so it stays at its reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (rf.reg_write && rf.rd_addr != '0) begin
      regs[rf.rd_addr] <= rf.write_data;
    end
  end

  // Bypass is suppressed during reset so the ports read 0 while it is held.
  assign bypass_hit1 = BYPASS && !reset && rf.reg_write && (rf.rd_addr == rf.rs1_addr);
  assign bypass_hit2 = BYPASS && !reset && rf.reg_write && (rf.rd_addr == rf.rs2_addr);

  // Read port 1: x0, then same-cycle write, then stored value.
  always_comb begin
    if (reset || rf.rs1_addr == '0) begin
      rf.read_data1 = '0;
    end else if (bypass_hit1) begin
      rf.read_data1 = rf.write_data;
    end else begin
      rf.read_data1 = regs[rf.rs1_addr];
    end
  end

  // Read port 2: same priority as port 1, fully independent.
  always_comb begin
    if (reset || rf.rs2_addr == '0) begin
      rf.read_data2 = '0;
    end else if (bypass_hit2) begin
      rf.read_data2 = rf.write_data;
    end else begin
      rf.read_data2 = regs[rf.rs2_addr];
    end
  end

  reg_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .pend_set  (rf.pend_set),
    .pend_addr (rf.pend_addr),
    .reg_write (rf.reg_write),
    .rd_addr   (rf.rd_addr),
    .rs1_addr  (rf.rs1_addr),
    .rs2_addr  (rf.rs2_addr),
    .pending   (rf.pending),
    .stall     (rf.stall)
  );

endmodule
